// File: rtl/hyperbus_burst_seq.sv
// hyperbus_burst_seq
//   Burst sequencer in front of the HyperBus primary controller. It turns user
//   burst commands into the controller's level-held rrq/wrq protocol, buffers
//   write words so every ready beat is fed, and collects read words into a
//   FIFO with user back-pressure. Single clock domain (clk90).
//
// Ports
//   clk90, rst                      clock, async active-high reset
//   cmd_valid/ready/adr/len/we/reg  burst command (len = words - 1)
//   wr_data/mask/valid/ready        write-word stream into the write FIFO
//   rd_data/valid/ready             read-word stream out of the read FIFO
//   hb_adr/dat/mask/reg_space       command and write data to the controller
//   hb_wrq/hb_rrq                   level-held write/read requests
//   hb_rdat/valid/ready/busy/error  controller responses
//   done                            one-cycle pulse at burst completion
//   err                             sticky error, cleared by rst only
module hyperbus_burst_seq #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDR_LENGTH = 32,
  parameter int unsigned LEN_WIDTH   = 4,
  parameter int unsigned WR_DEPTH    = 16,
  parameter int unsigned RD_DEPTH    = 16,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                     clk90,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_LENGTH-1:0]   cmd_adr,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic                     cmd_we,
  input  logic                     cmd_reg,
  input  logic [2*WIDTH-1:0]       wr_data,
  input  logic [1:0]               wr_mask,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [2*WIDTH-1:0]       rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ADDR_LENGTH-1:0]   hb_adr,
  output logic [2*WIDTH-1:0]       hb_dat,
  output logic [(2*WIDTH/8):0]     hb_mask,
  output logic                     hb_reg_space,
  output logic                     hb_wrq,
  output logic                     hb_rrq,
  input  logic [2*WIDTH-1:0]       hb_rdat,
  input  logic                     hb_valid,
  input  logic                     hb_ready,
  input  logic                     hb_busy,
  input  logic                     hb_error,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned DW  = 2 * WIDTH;
  localparam int unsigned MW  = (2 * WIDTH / 8) + 1;
  localparam int unsigned WAW = $clog2(WR_DEPTH);
  localparam int unsigned RAW = $clog2(RD_DEPTH);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WR_DATA, RD_DATA, DRAIN, ERROR} state_t;

  state_t state, state_nxt;

  // Low while in reset, high from the first clock edge after release; gates
  // the user-facing ready signals so they read 0 throughout reset.
  logic live;

  logic [DW+1:0]  wr_mem [WR_DEPTH];
  logic [WAW-1:0] wr_wptr, wr_rptr;
  logic [WAW:0]   wr_count;
  logic           wr_push, wr_pop;
  logic [DW+1:0]  wr_head;

  logic [DW-1:0]  rd_mem [RD_DEPTH];
  logic [RAW-1:0] rd_wptr, rd_rptr;
  logic [RAW:0]   rd_count;
  logic           rd_push, rd_pop;

  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [TW-1:0]        to_cnt;
  logic                 accept, beat;
  logic [31:0]          need, wr_avail, rd_free;

  assign need     = 32'(cmd_len) + 32'd1;
  assign wr_avail = 32'(wr_count);
  assign rd_free  = 32'(RD_DEPTH) - 32'(rd_count);

  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) live <= 1'b0;
    else     live <= 1'b1;
  end

  // ---------------- write FIFO ----------------
  assign wr_ready = live & (wr_count != (WAW+1)'(WR_DEPTH));
  assign wr_push  = wr_valid & wr_ready;
  assign wr_head  = wr_mem[wr_rptr];

  always_ff @(posedge clk90) begin
    if (wr_push) wr_mem[wr_wptr] <= {wr_mask, wr_data};
  end

  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      wr_wptr  <= '0;
      wr_rptr  <= '0;
      wr_count <= '0;
    end else begin
      if (wr_push) wr_wptr <= wr_wptr + WAW'(1);
      if (wr_pop)  wr_rptr <= wr_rptr + WAW'(1);
      case ({wr_push, wr_pop})
        2'b10:   wr_count <= wr_count + (WAW+1)'(1);
        2'b01:   wr_count <= wr_count - (WAW+1)'(1);
        default: wr_count <= wr_count;
      endcase
    end
  end

  // ---------------- read FIFO ----------------
  assign rd_valid = (rd_count != '0);
  assign rd_data  = rd_mem[rd_rptr];
  assign rd_pop   = rd_valid & rd_ready;

  always_ff @(posedge clk90) begin
    if (rd_push) rd_mem[rd_wptr] <= hb_rdat;
  end

  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      rd_wptr  <= '0;
      rd_rptr  <= '0;
      rd_count <= '0;
    end else begin
      if (rd_push) rd_wptr <= rd_wptr + RAW'(1);
      if (rd_pop)  rd_rptr <= rd_rptr + RAW'(1);
      case ({rd_push, rd_pop})
        2'b10:   rd_count <= rd_count + (RAW+1)'(1);
        2'b01:   rd_count <= rd_count - (RAW+1)'(1);
        default: rd_count <= rd_count;
      endcase
    end
  end

  // ---------------- sequencer FSM ----------------
  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Requests and error flag decode straight from the state register, so they
  // are registered and drop asynchronously with rst.
  assign hb_wrq = (state == WR_DATA);
  assign hb_rrq = (state == RD_DATA);
  assign err    = (state == ERROR);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    wr_pop    = 1'b0;
    rd_push   = 1'b0;
    beat      = 1'b0;
    done      = 1'b0;
    hb_dat    = '0;
    hb_mask   = MW'(2'b11);
    case (state)
      IDLE: begin
        // Admission only when the whole burst is already buffered (write) or
        // fits (read), so the controller never sees underrun or overflow.
        cmd_ready = live & ~hb_busy &
                    (cmd_we ? (wr_avail >= need) : (rd_free >= need));
        if (cmd_valid && cmd_ready) begin
          accept    = 1'b1;
          state_nxt = cmd_we ? WR_DATA : RD_DATA;
        end
      end
      WR_DATA: begin
        hb_dat  = wr_head[DW-1:0];
        hb_mask = MW'(wr_head[DW+1:DW]);
        if (hb_ready) begin
          wr_pop = (wr_count != '0);
          beat   = 1'b1;
          if (beat_cnt == '0) state_nxt = DRAIN;
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          state_nxt = ERROR;
        end
      end
      RD_DATA: begin
        if (hb_valid) begin
          rd_push = (rd_count != (RAW+1)'(RD_DEPTH));
          beat    = 1'b1;
          if (beat_cnt == '0) state_nxt = DRAIN;
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          state_nxt = ERROR;
        end
      end
      DRAIN: begin
        if (!hb_busy) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
    if (hb_error) begin
      state_nxt = ERROR;
      done      = 1'b0;
    end
  end

  // Command latch, beat counter and no-beat timeout counter.
  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      hb_adr       <= '0;
      hb_reg_space <= 1'b0;
      beat_cnt     <= '0;
      to_cnt       <= '0;
    end else if (accept) begin
      hb_adr       <= cmd_adr;
      hb_reg_space <= cmd_reg;
      beat_cnt     <= cmd_len;
      to_cnt       <= '0;
    end else if (beat) begin
      beat_cnt <= beat_cnt - LEN_WIDTH'(1);
      to_cnt   <= '0;
    end else if (state == WR_DATA || state == RD_DATA) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_hyperbus_burst_seq.sv
// tb_hyperbus_burst_seq
//   Self-checking bench for hyperbus_burst_seq: a table of command-admission
//   vectors plus hand-written write, read, admission, reset and timeout
//   sequences. Expected write beats and read words are queued when stimulus
//   is driven and compared when the DUT presents them.
module tb_hyperbus_burst_seq;

  logic        clk90 = 1'b0;
  logic        rst   = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_reg;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_len;
  logic [15:0] wr_data, rd_data, hb_dat, hb_rdat;
  logic [1:0]  wr_mask;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic [31:0] hb_adr;
  logic [2:0]  hb_mask;
  logic        hb_reg_space, hb_wrq, hb_rrq;
  logic        hb_valid, hb_ready, hb_busy, hb_error;
  logic        done, err;

  hyperbus_burst_seq #(
    .WIDTH(8), .ADDR_LENGTH(32), .LEN_WIDTH(4),
    .WR_DEPTH(16), .RD_DEPTH(16), .TIMEOUT(255)
  ) dut (
    .clk90(clk90), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr),
    .cmd_len(cmd_len), .cmd_we(cmd_we), .cmd_reg(cmd_reg),
    .wr_data(wr_data), .wr_mask(wr_mask), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .hb_adr(hb_adr), .hb_dat(hb_dat), .hb_mask(hb_mask), .hb_reg_space(hb_reg_space),
    .hb_wrq(hb_wrq), .hb_rrq(hb_rrq), .hb_rdat(hb_rdat), .hb_valid(hb_valid),
    .hb_ready(hb_ready), .hb_busy(hb_busy), .hb_error(hb_error),
    .done(done), .err(err)
  );

  always #5 clk90 = ~clk90;

  typedef struct {
    int         npush;
    logic       we;
    logic [3:0] len;
    logic       busy;
    logic       exp;
  } adm_t;

  adm_t        tbl [8];
  int          checks   = 0;
  int          failures = 0;
  int          done_cnt = 0;
  logic [17:0] wq [$];
  logic [15:0] rq [$];

  always @(negedge clk90) if (done) done_cnt = done_cnt + 1;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: expected DUT event did not occur", name);
  endtask

  task automatic step();
    @(posedge clk90);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d, input logic [1:0] m);
    wr_data  = d;
    wr_mask  = m;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    wq.push_back({m, d});
  endtask

  task automatic write_burst(input logic [31:0] adr, input logic [3:0] len);
    int          d0;
    int          beats;
    logic [17:0] e;
    hb_busy = 1'b0; cmd_we = 1'b1; cmd_adr = adr; cmd_len = len;
    cmd_reg = 1'b0; cmd_valid = 1'b1;
    @(negedge clk90);
    chk("wr_cmd_ready", 64'(cmd_ready), 64'(1));
    step();
    cmd_valid = 1'b0; hb_ready = 1'b1; hb_busy = 1'b1;
    d0 = done_cnt; beats = 0;
    @(negedge clk90);
    chk("wr_wrq_on", 64'(hb_wrq), 64'(1));
    chk("wr_adr", 64'(hb_adr), 64'(adr));
    for (int c = 0; c < 40; c++) begin
      if (!hb_wrq) break;
      if (wq.size() == 0) note_fail("wr_beat_unexpected");
      else begin
        e = wq.pop_front();
        chk("wr_beat", 64'({hb_mask, hb_dat}), 64'({1'b0, e}));
      end
      beats++;
      step();
      @(negedge clk90);
    end
    chk("wr_beats", 64'(beats), 64'(len) + 64'd1);
    chk("wr_wrq_drop", 64'(hb_wrq), 64'(0));
    chk("wr_extra_mask", 64'(hb_mask), 64'(3'b011));
    chk("wr_extra_dat", 64'(hb_dat), 64'(0));
    step();
    hb_ready = 1'b0;
    step();
    chk("wr_no_early_done", 64'(done_cnt - d0), 64'(0));
    hb_busy = 1'b0;
    repeat (3) step();
    chk("wr_done_once", 64'(done_cnt - d0), 64'(1));
  endtask

  task automatic read_burst(input logic [31:0] adr, input logic [3:0] len,
                            input logic [15:0] base, input logic extra);
    int d0;
    hb_busy = 1'b0; cmd_we = 1'b0; cmd_adr = adr; cmd_len = len;
    cmd_reg = 1'b1; cmd_valid = 1'b1;
    @(negedge clk90);
    chk("rd_cmd_ready", 64'(cmd_ready), 64'(1));
    step();
    cmd_valid = 1'b0;
    d0 = done_cnt;
    @(negedge clk90);
    chk("rd_rrq_on", 64'(hb_rrq), 64'(1));
    chk("rd_reg_space", 64'(hb_reg_space), 64'(1));
    chk("rd_adr", 64'(hb_adr), 64'(adr));
    step();
    for (int i = 0; i <= int'(len); i++) begin
      hb_valid = 1'b1; hb_busy = 1'b1;
      hb_rdat  = 16'(base + 16'(i));
      rq.push_back(hb_rdat);
      @(negedge clk90);
      chk("rd_rrq_held", 64'(hb_rrq), 64'(1));
      step();
    end
    // Last beat has been taken; an extra valid now must be discarded.
    hb_valid = extra;
    hb_rdat  = 16'(base + 16'(len) + 16'd1);
    @(negedge clk90);
    chk("rd_rrq_drop", 64'(hb_rrq), 64'(0));
    step();
    hb_valid = 1'b0;
    step();
    hb_busy = 1'b0;
    repeat (3) step();
    chk("rd_done_once", 64'(done_cnt - d0), 64'(1));
  endtask

  task automatic pop_one();
    logic [15:0] e;
    rd_ready = 1'b1;
    @(negedge clk90);
    if (rq.size() == 0) note_fail("rd_pop_unexpected");
    else begin
      e = rq.pop_front();
      if (!rd_valid) note_fail("rd_pop_empty");
      else chk("rd_word", 64'(rd_data), 64'(e));
    end
    step();
    rd_ready = 1'b0;
  endtask

  initial begin
    int k;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_reg = 1'b0; cmd_adr = '0; cmd_len = '0;
    wr_data = '0; wr_mask = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    hb_rdat = '0; hb_valid = 1'b0; hb_ready = 1'b0; hb_busy = 1'b0; hb_error = 1'b0;

    //            npush we    len    busy  exp
    tbl[0] = '{0, 1'b1, 4'd0,  1'b0, 1'b0};
    tbl[1] = '{2, 1'b1, 4'd3,  1'b0, 1'b0};
    tbl[2] = '{0, 1'b1, 4'd1,  1'b0, 1'b1};
    tbl[3] = '{0, 1'b1, 4'd1,  1'b1, 1'b0};
    tbl[4] = '{2, 1'b1, 4'd3,  1'b0, 1'b1};
    tbl[5] = '{0, 1'b1, 4'd4,  1'b0, 1'b0};
    tbl[6] = '{0, 1'b0, 4'd15, 1'b0, 1'b1};
    tbl[7] = '{0, 1'b0, 4'd15, 1'b1, 1'b0};

    // Reset values
    #1 rst = 1'b1;
    @(negedge clk90);
    chk("rst_wrq", 64'(hb_wrq), 64'(0));
    chk("rst_rrq", 64'(hb_rrq), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_wr_ready", 64'(wr_ready), 64'(0));
    chk("rst_adr", 64'(hb_adr), 64'(0));
    chk("rst_dat", 64'(hb_dat), 64'(0));
    chk("rst_reg_space", 64'(hb_reg_space), 64'(0));
    chk("rst_mask", 64'(hb_mask), 64'(3'b011));
    step(); step();
    rst = 1'b0;
    step();
    @(negedge clk90);
    chk("post_rst_wr_ready", 64'(wr_ready), 64'(1));
    step();

    // Admission vectors; words 0x1111..0x4444 accumulate in the write FIFO
    k = 0;
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < tbl[r].npush; p++) begin
        push_word(16'(16'h1111 * (k + 1)), (k == 2) ? 2'b10 : 2'b00);
        k++;
      end
      hb_busy = tbl[r].busy; cmd_we = tbl[r].we; cmd_len = tbl[r].len;
      cmd_valid = 1'b0;
      @(negedge clk90);
      chk($sformatf("adm_row%0d", r), 64'(cmd_ready), 64'(tbl[r].exp));
      chk("adm_no_wrq", 64'(hb_wrq), 64'(0));
      step();
    end

    // Write burst of the four buffered words
    write_burst(32'h100, 4'd3);

    // Read burst with back-pressure and a discarded ninth valid
    read_burst(32'h200, 4'd7, 16'hA000, 1'b1);
    @(negedge clk90);
    chk("rd_held_valid", 64'(rd_valid), 64'(1));
    step();
    for (int i = 0; i < 8; i++) pop_one();
    @(negedge clk90);
    chk("rd_empty_after8", 64'(rd_valid), 64'(0));
    step();

    // Read admission with 12 words resident
    read_burst(32'h300, 4'd11, 16'hB000, 1'b0);
    cmd_we = 1'b0; cmd_len = 4'd7; cmd_valid = 1'b0;
    @(negedge clk90);
    chk("rd_adm_12", 64'(cmd_ready), 64'(0));
    step();
    for (int p = 0; p < 4; p++) begin
      pop_one();
      @(negedge clk90);
      chk($sformatf("rd_adm_pop%0d", p), 64'(cmd_ready), 64'(p == 3));
      step();
    end
    for (int i = 0; i < 8; i++) pop_one();
    @(negedge clk90);
    chk("rd_empty_after12", 64'(rd_valid), 64'(0));
    step();

    // Reset during write beat 2
    for (int i = 0; i < 4; i++) push_word(16'(16'h5555 + 16'h1111 * i), 2'b00);
    cmd_we = 1'b1; cmd_len = 4'd3; cmd_adr = 32'h400; cmd_valid = 1'b1;
    @(negedge clk90);
    chk("mid_cmd_ready", 64'(cmd_ready), 64'(1));
    step();
    cmd_valid = 1'b0; hb_ready = 1'b1; hb_busy = 1'b1;
    @(negedge clk90);
    chk("mid_beat1", 64'({hb_mask, hb_dat}), 64'({1'b0, wq.pop_front()}));
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_wrq", 64'(hb_wrq), 64'(0));
    chk("mid_rst_wr_ready", 64'(wr_ready), 64'(0));
    wq.delete();
    hb_ready = 1'b0; hb_busy = 1'b0;
    step(); step();
    rst = 1'b0; cmd_we = 1'b1; cmd_len = 4'd0;
    step();
    @(negedge clk90);
    chk("mid_wr_ready", 64'(wr_ready), 64'(1));
    chk("mid_rd_empty", 64'(rd_valid), 64'(0));
    chk("mid_wr_empty", 64'(cmd_ready), 64'(0));
    step();
    push_word(16'h9999, 2'b01);
    push_word(16'hAAAA, 2'b00);
    write_burst(32'h500, 4'd1);

    // Timeout: read request never answered
    hb_busy = 1'b0; cmd_we = 1'b0; cmd_len = 4'd0; cmd_valid = 1'b1;
    @(negedge clk90);
    chk("to_cmd_ready", 64'(cmd_ready), 64'(1));
    step();
    cmd_valid = 1'b0; hb_busy = 1'b1;
    repeat (254) step();
    @(negedge clk90);
    chk("to_rrq_254", 64'(hb_rrq), 64'(1));
    chk("to_err_254", 64'(err), 64'(0));
    step();
    @(negedge clk90);
    chk("to_rrq_255", 64'(hb_rrq), 64'(0));
    chk("to_err_255", 64'(err), 64'(1));
    step();
    hb_busy = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk90);
      chk("err_cmd_blocked", 64'(cmd_ready), 64'(0));
      chk("err_no_rrq", 64'(hb_rrq), 64'(0));
      chk("err_sticky", 64'(err), 64'(1));
      step();
    end
    cmd_valid = 1'b0;
    @(negedge clk90);
    chk("err_wr_pushable", 64'(wr_ready), 64'(1));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
